// File: rtl/fifo_stream_reader.sv
// Read-side adapter that turns a FIFO with one-cycle read latency into a valid/ready stream.
// A 3-entry skid buffer covers the in-flight read, so the read decision never depends on m_ready.
module fifo_stream_reader #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 fifo_empty,
  input  logic [WIDTH-1:0]     fifo_dout,
  output logic                 fifo_rd_en,
  output logic                 m_valid,
  output logic [WIDTH-1:0]     m_data,
  input  logic                 m_ready,
  output logic [CNT_WIDTH-1:0] beat_count,
  output logic                 idle
);

  logic [WIDTH-1:0] buffer [3];
  logic [1:0]       head;
  logic [1:0]       tail;
  logic [1:0]       occ;
  logic             inflight;
  logic             pop;

  function automatic logic [1:0] wrap_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign m_valid = (occ != 2'd0);
  assign m_data  = buffer[head];
  assign pop     = m_valid && m_ready;
  assign idle    = fifo_empty && (occ == 2'd0) && !inflight;

  // Only issue a read when the buffer is guaranteed to have room for it on return.
  assign fifo_rd_en = rst_n && !fifo_empty && (({1'b0, occ} + {2'b00, inflight}) <= 3'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 3; i++) buffer[i] <= '0;
      head       <= '0;
      tail       <= '0;
      occ        <= '0;
      inflight   <= 1'b0;
      beat_count <= '0;
    end else begin
      inflight <= fifo_rd_en;
      if (inflight) begin
        buffer[tail] <= fifo_dout;
        tail         <= wrap_inc(tail);
      end
      if (pop) begin
        head       <= wrap_inc(head);
        beat_count <= beat_count + CNT_WIDTH'(1);
      end
      occ <= occ + {1'b0, inflight} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: queue-based FIFO model, ordered scoreboard, table and directed sequences.
module tb_fifo_stream_reader;
  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [W-1:0]  fifo_dout = '0;
  logic          fifo_rd_en;
  logic          m_valid;
  logic [W-1:0]  m_data;
  logic          m_ready = 1'b0;
  logic [CW-1:0] beat_count;
  logic          idle;

  fifo_stream_reader #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_rd_en(fifo_rd_en), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .beat_count(beat_count), .idle(idle)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // FIFO model: writes land at the next edge, reads return data one edge later.
  logic [W-1:0] fq[$];
  logic [W-1:0] wq[$];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fq.delete();
      fifo_empty <= 1'b1;
      fifo_dout  <= '0;
    end else begin
      if (fifo_rd_en && fq.size() > 0) fifo_dout <= fq.pop_front();
      while (wq.size() > 0) fq.push_back(wq.pop_front());
      fifo_empty <= (fq.size() == 0);
    end
  end

  // Scoreboard: words must come out in write order; outstanding = reads issued - beats taken.
  logic [W-1:0] exp_q[$];
  int           out_cnt = 0;
  int           bc_model = 0;
  int           rd_cnt = 0;
  logic         prev_hold = 1'b0;
  logic [W-1:0] prev_data = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      out_cnt   = 0;
      bc_model  = 0;
      prev_hold = 1'b0;
    end else begin
      chk("beat_count", 32'(beat_count), 32'(bc_model));
      chk("idle", 32'(idle), 32'(fifo_empty && out_cnt == 0));
      chk("rd_while_empty", 32'(fifo_rd_en && fifo_empty), 32'd0);
      if (prev_hold) begin
        chk("hold_valid", 32'(m_valid), 32'd1);
        chk("hold_data", 32'(m_data), 32'(prev_data));
      end
      if (m_valid && m_ready) begin
        chk("spurious_beat", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) chk("beat_data", 32'(m_data), 32'(exp_q.pop_front()));
        bc_model = (bc_model + 1) % (1 << CW);
        out_cnt--;
      end
      if (fifo_rd_en) begin
        out_cnt++;
        rd_cnt++;
      end
      chk("outstanding_le3", 32'(out_cnt <= 3 && out_cnt >= 0), 32'd1);
      prev_hold = m_valid && !m_ready;
      prev_data = m_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] d);
    wq.push_back(d);
    exp_q.push_back(d);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    m_ready = 1'b1;
    while (!(idle && wq.size() == 0) && n < budget) begin
      step();
      n++;
    end
    chk("drain_done", 32'(idle && wq.size() == 0), 32'd1);
    chk("all_delivered", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n   = 1'b0;
    m_ready = 1'b0;
    wq.delete();
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic         rdy;
    logic         rd;
    logic         vld;
    logic [W-1:0] data;
    logic [CW-1:0] bc;
    logic         idl;
  } vec_t;
  vec_t vt[11];

  initial begin
    int base;
    vt[0]  = '{1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0};
    vt[1]  = '{1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0};
    vt[2]  = '{1'b1, 1'b1, 1'b1, 8'h11, 4'd0, 1'b0};
    vt[3]  = '{1'b1, 1'b1, 1'b1, 8'h12, 4'd1, 1'b0};
    vt[4]  = '{1'b1, 1'b1, 1'b1, 8'h13, 4'd2, 1'b0};
    vt[5]  = '{1'b1, 1'b1, 1'b1, 8'h14, 4'd3, 1'b0};
    vt[6]  = '{1'b1, 1'b1, 1'b1, 8'h15, 4'd4, 1'b0};
    vt[7]  = '{1'b1, 1'b1, 1'b1, 8'h16, 4'd5, 1'b0};
    vt[8]  = '{1'b1, 1'b0, 1'b1, 8'h17, 4'd6, 1'b0};
    vt[9]  = '{1'b1, 1'b0, 1'b1, 8'h18, 4'd7, 1'b0};
    vt[10] = '{1'b1, 1'b0, 1'b0, 8'h00, 4'd8, 1'b1};

    #12;
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("rst_beat_count", 32'(beat_count), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Full-throughput stream of 8 words
    for (int i = 0; i < 8; i++) push(8'(8'h11 + i));
    step();
    for (int i = 0; i < 11; i++) begin
      m_ready = vt[i].rdy;
      @(negedge clk);
      chk($sformatf("t1_rd_en[%0d]", i), 32'(fifo_rd_en), 32'(vt[i].rd));
      chk($sformatf("t1_valid[%0d]", i), 32'(m_valid), 32'(vt[i].vld));
      if (vt[i].vld) chk($sformatf("t1_data[%0d]", i), 32'(m_data), 32'(vt[i].data));
      chk($sformatf("t1_beats[%0d]", i), 32'(beat_count), 32'(vt[i].bc));
      chk($sformatf("t1_idle[%0d]", i), 32'(idle), 32'(vt[i].idl));
      step();
    end

    // Backpressure: 5 words, only 3 reads while stalled, then gapless restart
    m_ready = 1'b0;
    base = rd_cnt;
    for (int i = 0; i < 5; i++) push(8'(8'hA0 + i));
    repeat (11) step();
    chk("bp_reads", 32'(rd_cnt - base), 32'd3);
    chk("bp_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("bp_valid", 32'(m_valid), 32'd1);
    chk("bp_data", 32'(m_data), 32'hA0);
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_restart_valid[%0d]", i), 32'(m_valid), 32'd1);
      chk($sformatf("bp_restart_data[%0d]", i), 32'(m_data), 32'(8'hA0 + i));
      step();
    end
    drain(20);

    // Alternating m_ready with 16 words
    for (int i = 0; i < 16; i++) push(8'(8'h30 + i));
    for (int c = 0; c < 40; c++) begin
      m_ready = (c % 2 == 0);
      step();
    end
    drain(40);

    // Single word, idle gap, then a second word 6 cycles later
    m_ready = 1'b1;
    push(8'h5A);
    step();
    chk("sw_rd_e0", 32'(fifo_rd_en), 32'd1);
    step();
    chk("sw_valid_e1", 32'(m_valid), 32'd0);
    step();
    chk("sw_valid_e2", 32'(m_valid), 32'd1);
    chk("sw_data_e2", 32'(m_data), 32'h5A);
    step();
    chk("sw_valid_e3", 32'(m_valid), 32'd0);
    chk("sw_idle_e3", 32'(idle), 32'd1);
    step();
    chk("sw_idle_e4", 32'(idle), 32'd1);
    step();
    push(8'h5B);
    chk("sw_idle_e5", 32'(idle), 32'd1);
    step();
    chk("sw_rd_e6", 32'(fifo_rd_en), 32'd1);
    chk("sw_idle_e6", 32'(idle), 32'd0);
    step();
    chk("sw_valid_e7", 32'(m_valid), 32'd0);
    step();
    chk("sw_valid_e8", 32'(m_valid), 32'd1);
    chk("sw_data_e8", 32'(m_data), 32'h5B);
    drain(10);

    // beat_count wrap: 18 beats on a 4-bit counter
    do_reset();
    for (int i = 0; i < 18; i++) push(8'(8'hC0 + i));
    drain(40);
    chk("wrap_final", 32'(beat_count), 32'd2);

    // Reset with occ=2, inflight=1
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(8'(8'hB0 + i));
    step();
    chk("mr_rd_c0", 32'(fifo_rd_en), 32'd1);
    repeat (3) step();
    chk("mr_valid_c3", 32'(m_valid), 32'd1);
    chk("mr_rd_c3", 32'(fifo_rd_en), 32'd0);
    #2;
    rst_n = 1'b0;
    wq.delete();
    #1;
    chk("mr_valid_rst", 32'(m_valid), 32'd0);
    chk("mr_rd_rst", 32'(fifo_rd_en), 32'd0);
    chk("mr_beats_rst", 32'(beat_count), 32'd0);
    chk("mr_data_rst", 32'(m_data), 32'd0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) push(8'(8'hD0 + i));
    step();
    chk("mr_first_rd", 32'(fifo_rd_en), 32'd1);
    drain(30);

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 2) == 0) push(8'($urandom));
      if ($urandom_range(0, 9) == 0) push(8'($urandom));
      m_ready = (c / 150) % 2 == 0 ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      step();
    end
    drain(600);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
Read-side adapter for the team's synchronous FIFO. It drives the FIFO's rd_en / dout / empty port, which has one-cycle registered read latency. It re-presents the data as a valid/ready stream with full throughput and a registered-only read decision, so there is no combinational path from m_ready to fifo_rd_en. It sits between a FIFO instance and any downstream stream consumer.

Parameters:
WIDTH, 8, data width; must equal the attached FIFO's WIDTH.
CNT_WIDTH, 16, width of the delivered-beat counter.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
fifo_empty  input  1  FIFO empty flag.
fifo_dout  input  WIDTH  FIFO read data; valid in the cycle after a read is issued.
fifo_rd_en  output  1  FIFO read request.
m_valid  output  1  stream data valid.
m_data  output  WIDTH  stream data.
m_ready  input  1  downstream accepts.
beat_count  output  CNT_WIDTH  number of stream beats delivered, wrapping.
idle  output  1  nothing pending anywhere.

Behaviour:
- Reset is asynchronous on rst_n falling. The following all clear to 0:
  - 3-entry skid buffer occupancy (occ, range 0..3), buffer head/tail pointers, inflight flag, beat_count.
  - Consequently m_valid=0 and m_data=0 (m_data shows entry 0, which is cleared).
  - fifo_rd_en is forced 0 while rst_n=0.
- Read issue rule, combinational from registered state plus fifo_empty only: fifo_rd_en = rst_n && !fifo_empty && (occ + inflight <= 2). m_ready never feeds fifo_rd_en.
- inflight <= fifo_rd_en at every edge.
- Capture: at an edge where inflight=1, fifo_dout is written at the tail and the tail advances (mod 3). A read issued in cycle t is therefore captured at the end of cycle t+1, and a new read may be issued every cycle.
- Pop:
  - m_valid = (occ != 0); m_data = buffer[head], driven from a register with no muxing from fifo_dout.
  - pop = m_valid && m_ready; on pop the head advances (mod 3).
- Occupancy: occ_next = occ + capture - pop. Simultaneous capture and pop leaves occ unchanged.
- Ordering: beats are delivered in exact FIFO order; no drop, no duplication.
- Capacity invariant: occ + inflight <= 3 at all times, and the buffer never overflows. The bench asserts this.
- Throughput: with the FIFO non-empty and m_ready held at 1, steady state is one beat per cycle after a 2-cycle startup latency (rd_en in cycle 0, m_valid in cycle 2).
- Backpressure: with m_ready=0, reads stop once occ + inflight = 3. Data is held stable and m_valid stays 1 until it is accepted.
- beat_count increments by 1 on each pop and wraps from 2^CNT_WIDTH-1 to 0.
- idle = fifo_empty && occ==0 && !inflight.
- FIFO empty mid-stream: no read is issued. Buffered data still drains, and reads resume the cycle fifo_empty falls.
- Reset mid-operation: buffered and inflight data are discarded, and the attached FIFO is expected to be reset together with this block. After reset release, the first fifo_rd_en can occur in the first cycle with fifo_empty=0.

Test Plan:
- Preload FIFO with 0x11..0x18, hold m_ready=1 -> fifo_rd_en high cycles 0-7; m_data 0x11..0x18 on consecutive cycles 2-9; beat_count=8; idle=1 at cycle 10.
- Preload 5 words 0xA0..0xA4, m_ready=0 for 10 cycles -> exactly 3 reads issued, occ=3, m_valid=1, m_data=0xA0 held stable. Then m_ready=1 -> 0xA0..0xA4 in order, no gaps after the restart.
- m_ready toggles 1,0,1,0 with 16 words streaming -> every word delivered once, in order; occ+inflight never exceeds 3; fifo_rd_en never asserted while fifo_empty=1.
- Write 1 word (0x5A), then a second word (0x5B) 6 cycles later -> m_valid pulses for 0x5A; idle=1 between the words; 0x5B emerges 2 cycles after its fifo_empty fall.
- CNT_WIDTH=4, stream 18 beats -> beat_count wraps 15->0 and ends at 2.
- Assert rst_n=0 with occ=2 and inflight=1 -> immediately m_valid=0, fifo_rd_en=0, beat_count=0. After release with a refilled FIFO, normal ordered streaming resumes.
